// File: rtl/list_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : list_arbiter
// Brief    : Round-robin sharing of one list instance between NUM_REQ ports,
//            with op_done watchdog and one-cycle per-requester response strobe.
// Revision : 1.0 - initial release
// ============================================================================
module list_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int LENGTH         = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LENGTH_WIDTH  = $clog2(LENGTH),
    localparam int GRANT_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*3-1:0]               req_op_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_in,
    input  logic [NUM_REQ*LENGTH_WIDTH-1:0]    req_index_in,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH+LENGTH_WIDTH-1:0] rsp_data,
    output logic                               rsp_error,
    output logic                               rsp_timeout,
    output logic [GRANT_WIDTH-1:0]             grant_id,
    output logic                               busy,
    output logic [2:0]                         list_op_sel,
    output logic                               list_op_en,
    output logic [DATA_WIDTH-1:0]              list_data_in,
    output logic [LENGTH_WIDTH-1:0]            list_index_in,
    input  logic [DATA_WIDTH+LENGTH_WIDTH-1:0] list_data_out,
    input  logic                               list_op_done,
    input  logic                               list_op_error
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]   C_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [GRANT_WIDTH:0]   C_NUM_REQ  = (GRANT_WIDTH + 1)'(NUM_REQ);
    localparam logic [GRANT_WIDTH-1:0] C_LAST_REQ = GRANT_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [GRANT_WIDTH-1:0]  r_rr_ptr;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [GRANT_WIDTH-1:0]  w_winner;
    logic [GRANT_WIDTH:0]    w_idx;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_timeout;

    logic [2:0]              w_op    [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_data  [NUM_REQ];
    logic [LENGTH_WIDTH-1:0] w_index [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_op[g]    = req_op_sel[g*3 +: 3];
            assign w_data[g]  = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
            assign w_index[g] = req_index_in[g*LENGTH_WIDTH +: LENGTH_WIDTH];
        end
    endgenerate

    // First valid requester at or above the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (GRANT_WIDTH + 1)'(k);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (!w_found && req_valid[w_idx[GRANT_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[GRANT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !rst) begin
                    req_ready[w_winner] = 1'b1;
                    w_accept            = 1'b1;
                    w_state_next        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A done arriving on the last watchdog cycle still counts as a completion.
                if (list_op_done) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            grant_id      <= '0;
            list_op_sel   <= '0;
            list_op_en    <= 1'b0;
            list_data_in  <= '0;
            list_index_in <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (w_accept) begin
                list_op_sel   <= w_op[w_winner];
                list_data_in  <= w_data[w_winner];
                list_index_in <= w_index[w_winner];
                grant_id      <= w_winner;
                r_rr_ptr      <= (w_winner == C_LAST_REQ) ? '0 : w_winner + 1'b1;
                list_op_en    <= 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_RESP) begin
                r_cnt <= '0;
            end
            if (w_capture) begin
                rsp_data            <= list_data_out;
                rsp_error           <= list_op_error;
                rsp_timeout         <= 1'b0;
                list_op_en          <= 1'b0;
                rsp_valid[grant_id] <= 1'b1;
            end
            if (w_timeout) begin
                rsp_data            <= '0;
                rsp_error           <= 1'b1;
                rsp_timeout         <= 1'b1;
                list_op_en          <= 1'b0;
                rsp_valid[grant_id] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_list_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_list_arbiter
// Brief    : Directed, table-driven bench for list_arbiter with a small list stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_list_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int LEN = 8;
    localparam int LW = 3;
    localparam int GW = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*3-1:0]   req_op_sel;
    logic [NR*DW-1:0]  req_data_in;
    logic [NR*LW-1:0]  req_index_in;
    logic [NR-1:0]     rsp_valid;
    logic [DW+LW-1:0]  rsp_data;
    logic              rsp_error;
    logic              rsp_timeout;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic [2:0]        list_op_sel;
    logic              list_op_en;
    logic [DW-1:0]     list_data_in;
    logic [LW-1:0]     list_index_in;
    logic [DW+LW-1:0]  list_data_out;
    logic              list_op_done;
    logic              list_op_error;

    always #5 clk = ~clk;

    list_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .LENGTH(LEN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_sel(req_op_sel), .req_data_in(req_data_in), .req_index_in(req_index_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .grant_id(grant_id), .busy(busy),
        .list_op_sel(list_op_sel), .list_op_en(list_op_en),
        .list_data_in(list_data_in), .list_index_in(list_index_in),
        .list_data_out(list_data_out), .list_op_done(list_op_done),
        .list_op_error(list_op_error)
    );

    // List stub: op 0 = read, op 1 = insert, others echo {index, data}; done 2 cycles after op_en.
    logic [DW-1:0]  mem [LEN];
    logic [LEN-1:0] vld;
    int             lat;
    bit             hang = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            list_op_done  <= 1'b0;
            list_op_error <= 1'b0;
            list_data_out <= '0;
            vld           <= '0;
            lat           <= 0;
        end else if (!list_op_en || list_op_done) begin
            list_op_done <= 1'b0;
            lat          <= 0;
        end else if (!hang) begin
            if (lat < 1) begin
                lat <= lat + 1;
            end else begin
                list_op_done <= 1'b1;
                case (list_op_sel)
                    3'd0: begin
                        list_op_error <= !vld[list_index_in];
                        list_data_out <= vld[list_index_in] ? {list_index_in, mem[list_index_in]} : '0;
                    end
                    3'd1: begin
                        mem[list_index_in] <= list_data_in;
                        vld[list_index_in] <= 1'b1;
                        list_op_error      <= 1'b0;
                        list_data_out      <= {list_index_in, list_data_in};
                    end
                    default: begin
                        list_op_error <= 1'b0;
                        list_data_out <= {list_index_in, list_data_in};
                    end
                endcase
            end
        end
    end

    int r1_acc = 0;
    always @(posedge clk) begin
        if (req_valid[1] && req_ready[1]) r1_acc <= r1_acc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic raise(input int r, input logic [2:0] op, input logic [LW-1:0] idx,
                         input logic [DW-1:0] d);
        req_valid[r]            = 1'b1;
        req_op_sel[3*r +: 3]    = op;
        req_data_in[DW*r +: DW] = d;
        req_index_in[LW*r +: LW] = idx;
    endtask

    // Waits for req_ready[r], lets the accepting edge pass, then drops valid.
    task automatic wait_accept(input int r, output bit ok);
        ok = 1'b0;
        #1;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (req_ready[r]) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        if (ok) begin
            check("ready_onehot", 32'(req_ready), 32'(1 << r));
            @(posedge clk);
            #1;
        end else begin
            bound_fail("ready_wait");
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) ok = 1'b1;
        end
        if (!ok) bound_fail("rsp_wait");
    endtask

    typedef struct {
        int              req;
        logic [2:0]      op;
        logic [LW-1:0]   idx;
        logic [DW-1:0]   data;
        logic            exp_err;
        logic [DW+LW-1:0] exp_data;
    } vec_t;

    task automatic do_cmd(input vec_t v);
        bit ok;
        @(negedge clk);
        raise(v.req, v.op, v.idx, v.data);
        wait_accept(v.req, ok);
        if (ok) begin
            @(negedge clk);
            check("issue_op_en", 32'(list_op_en), 32'd1);
            check("issue_ready_low", 32'(req_ready), 32'd0);
            check("issue_op_sel", 32'(list_op_sel), 32'(v.op));
            check("issue_data_in", 32'(list_data_in), 32'(v.data));
            check("issue_index_in", 32'(list_index_in), 32'(v.idx));
            check("issue_grant_id", 32'(grant_id), 32'(v.req));
            wait_rsp(ok);
            if (ok) begin
                check("rsp_valid", 32'(rsp_valid), 32'(1 << v.req));
                check("rsp_error", 32'(rsp_error), 32'(v.exp_err));
                check("rsp_timeout", 32'(rsp_timeout), 32'd0);
                check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
                check("rsp_op_en_low", 32'(list_op_en), 32'd0);
            end
        end
    endtask

    vec_t vecs [8];

    initial begin
        bit   ok;
        int   cnt;
        int   acc_snap;
        logic [NR-1:0] seen;
        vec_t v;

        vecs[0] = '{0, 3'd1, 3'd0, 8'h2A, 1'b0, {3'd0, 8'h2A}};
        vecs[1] = '{0, 3'd0, 3'd0, 8'h00, 1'b0, {3'd0, 8'h2A}};
        vecs[2] = '{2, 3'd0, 3'd5, 8'h00, 1'b1, 11'd0};
        vecs[3] = '{1, 3'd1, 3'd3, 8'h5C, 1'b0, {3'd3, 8'h5C}};
        vecs[4] = '{3, 3'd0, 3'd3, 8'h00, 1'b0, {3'd3, 8'h5C}};
        vecs[5] = '{1, 3'd7, 3'd6, 8'h11, 1'b0, {3'd6, 8'h11}};
        vecs[6] = '{2, 3'd5, 3'd2, 8'h80, 1'b0, {3'd2, 8'h80}};
        vecs[7] = '{3, 3'd0, 3'd7, 8'h00, 1'b1, 11'd0};

        rst = 1'b1;
        req_valid = '0;
        req_op_sel = '0;
        req_data_in = '0;
        req_index_in = '0;
        #12;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_op_en", 32'(list_op_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_cmd(vecs[i]);

        // Round robin with all four holding Read(0): grants 0,1,2,3,0.
        @(negedge clk);
        for (int r = 0; r < NR; r++) raise(r, 3'd0, 3'd0, 8'h00);
        for (int n = 0; n < 5; n++) begin
            wait_rsp(ok);
            if (ok) begin
                check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (n % 4)));
                check("rr_onehot", 32'($countones(rsp_valid)), 32'd1);
                check("rr_op_en_gap", 32'(list_op_en), 32'd0);
                check("rr_rsp_data", 32'(rsp_data), 32'({3'd0, 8'h2A}));
            end
            if (n == 4) req_valid = '0;
        end

        // Watchdog: stub never completes.
        hang = 1'b1;
        @(negedge clk);
        raise(1, 3'd2, 3'd1, 8'h44);
        wait_accept(1, ok);
        if (ok) begin
            cnt = 0;
            @(negedge clk);
            for (int g = 0; g < 100 && list_op_en; g++) begin
                cnt++;
                @(negedge clk);
            end
            check("to_op_en_cycles", 32'(cnt), 32'(TO));
            check("to_rsp_valid", 32'(rsp_valid), 32'b0010);
            check("to_rsp_error", 32'(rsp_error), 32'd1);
            check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
            check("to_rsp_data", 32'(rsp_data), 32'd0);
        end
        hang = 1'b0;
        v = '{2, 3'd0, 3'd0, 8'h00, 1'b0, {3'd0, 8'h2A}};
        do_cmd(v);

        // Asynchronous reset two cycles into ISSUE.
        hang = 1'b1;
        @(negedge clk);
        raise(3, 3'd1, 3'd4, 8'h77);
        wait_accept(3, ok);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_op_en", 32'(list_op_en), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_op_en", 32'(list_op_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_grant_id", 32'(grant_id), 32'd0);
        check("arst_op_sel", 32'(list_op_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hang = 1'b0;
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("arst_no_rsp", 32'(seen), 32'd0);
        raise(1, 3'd1, 3'd2, 8'h33);
        raise(3, 3'd1, 3'd4, 8'h77);
        wait_accept(1, ok);
        wait_rsp(ok);
        if (ok) check("post_rst_first", 32'(rsp_valid), 32'b0010);
        wait_accept(3, ok);
        wait_rsp(ok);
        if (ok) begin
            check("post_rst_second", 32'(rsp_valid), 32'b1000);
            check("post_rst_data", 32'(rsp_data), 32'({3'd4, 8'h77}));
        end

        // Move rr pointer to 3, then req1 withdraws while req3 holds the grant.
        v = '{2, 3'd0, 3'd4, 8'h00, 1'b0, {3'd4, 8'h77}};
        do_cmd(v);
        acc_snap = r1_acc;
        @(negedge clk);
        raise(1, 3'd1, 3'd0, 8'hEE);
        raise(3, 3'd0, 3'd2, 8'h00);
        #1;
        check("drop_ready_r3", 32'(req_ready), 32'b1000);
        wait_accept(3, ok);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(ok);
        if (ok) begin
            check("drop_rsp_valid", 32'(rsp_valid), 32'b1000);
            check("drop_rsp_data", 32'(rsp_data), 32'({3'd2, 8'h33}));
        end
        seen = '0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
            if (list_op_en) cnt++;
        end
        check("drop_no_rsp", 32'(seen), 32'd0);
        check("drop_no_op_en", 32'(cnt), 32'd0);
        check("drop_r1_accepts", 32'(r1_acc - acc_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
